x_300_mod_107_loader: RTL and testbench
=======================================

X_300_MOD_107_LOADER -- requirements
Module: x_300_mod_107_loader

Interface
REQ-001 The block SHALL have no parameters; word width 32, word count 10 and modulus 107 are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous abort of any partial operand or pending result.
REQ-005 in_valid  input  1  in_data carries an operand word.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 in_data  input  32  operand word, least-significant word first.
REQ-008 out_valid  output  1  out_r holds a valid residue.
REQ-009 out_ready  input  1  downstream accepts out_r.
REQ-010 out_r  output  7  residue X mod 107, range 0..106.
REQ-011 word_cnt  output  4  number of words accepted for the current operand, 0..9.

Function
REQ-012 Word k (k=0..9) SHALL be accepted when in_valid and in_ready are both high at a rising edge.
REQ-013 Word k SHALL be written to operand bits X[32k+32:32k+1] for k=0..8.
REQ-014 Word 9 SHALL write in_data[12:1] to X[300:289]; in_data[32:13] SHALL be ignored.
REQ-015 The residue SHALL be computed by an instance of x_300_mod_107, with its X input driven from the 300-bit operand register.
REQ-016 States SHALL be LOAD, CALC and HOLD.
REQ-017 LOAD: in_ready=1 and out_valid=0; each accepted word increments word_cnt.
REQ-018 LOAD: acceptance of word 9 SHALL transition to CALC and set word_cnt to 0.
REQ-019 CALC: lasts exactly one cycle; in_ready=0; out_r is registered from the instance output; transitions to HOLD.
REQ-020 HOLD: out_valid=1, in_ready=0, and out_r is stable.
REQ-021 HOLD: while out_ready=0, the block SHALL remain in HOLD.
REQ-022 HOLD: out_valid and out_ready both high at an edge SHALL transition to LOAD.
REQ-023 Latency: if word 9 is accepted at edge N, out_valid SHALL be high from just after edge N+1.
REQ-024 Throughput: at most one operand per 12 cycles; in_ready SHALL NOT be asserted in the HOLD-exit cycle.
REQ-025 The operand register SHALL NOT be cleared between operands; every bit is overwritten by the 10 words.
REQ-026 flush=1 at an edge, in any state, SHALL force LOAD, word_cnt=0 and out_valid=0.
REQ-027 flush SHALL take priority over a simultaneous word acceptance or output handshake; that word or result is discarded.
REQ-028 in_valid while in_ready=0 SHALL have no effect; the upstream holds the word.
REQ-029 out_r SHALL always be in the range 0..106 whenever out_valid=1.

Reset
REQ-030 While rst_n=0, the block SHALL immediately enter LOAD with word_cnt=0, out_valid=0, out_r=0, in_ready=1 and the operand register cleared.
REQ-031 Assertion of reset mid-load or in HOLD SHALL discard the partial operand or pending result with no output.
REQ-032 The first rising edge after reset deassertion MAY accept word 0.

Verification
REQ-033 Zero and modulus:
- all ten words 0 -> out_r=0.
- word0=0x0000006B, others 0 -> out_r=0.
- word0=0x0000006C, others 0 -> out_r=1.
REQ-034 Word weighting: word1=0x00000001, others 0 -> out_r=29 (2^32 mod 107).
REQ-035 Word-9 masking: word9=0xFFFFF000, others 0 -> out_r=0.
- Same operand with word9=0x00000001 -> out_r = 2^288 mod 107, checked against the reference model.
REQ-036 Backpressure: out_ready=0 for 5 cycles -> out_valid remains 1, out_r remains stable, in_ready remains 0.
- Raise out_ready -> state returns to LOAD the next cycle.
REQ-037 Flush:
- flush after 4 words -> word_cnt=0.
- A following full 10-word operand yields its own residue, uncorrupted by the partial words.
- flush in HOLD -> out_valid drops the next cycle.
REQ-038 Random and reset:
- 1000 random operands with random in_valid and out_ready gaps -> every out_r equals a big-integer X mod 107.
- Asynchronous reset pulse mid-CALC -> out_valid=0 immediately and no residue emitted.

Source files
------------

// File: rtl/x_300_mod_107_loader.sv
// Loads a 300-bit operand as ten 32-bit words (least-significant word first).
// It then returns the operand modulo 107 through a valid/ready output.

module x_300_mod_107 (
  input  logic [299:0] x,
  output logic [6:0]   r
);

  logic [14:0] weighted_sum;
  logic [12:0] fold1;
  logic [9:0]  fold2;
  logic [8:0]  fold3;

  // Each set bit adds 2^i mod 107. The weight chain depends only on the loop
  // index, so synthesis reduces it to constants.
  always_comb begin : weight_sum
    logic [7:0] w;
    weighted_sum = '0;
    w = 8'd1;
    for (int i = 0; i < 300; i++) begin
      if (x[i]) weighted_sum = weighted_sum + {8'b0, w[6:0]};
      w = {w[6:0], 1'b0};
      if (w >= 8'd107) w = w - 8'd107;
    end
  end

  // 128 is congruent to 21 mod 107, so each fold keeps the value congruent
  // while shrinking it. Two conditional subtractions then finish the job.
  always_comb begin
    fold1 = 13'(weighted_sum[14:7]) * 13'd21 + 13'(weighted_sum[6:0]);
    fold2 = 10'(fold1[12:7]) * 10'd21 + 10'(fold1[6:0]);
    fold3 = 9'(fold2[9:7]) * 9'd21 + 9'(fold2[6:0]);
    r = fold3[6:0];
    if (fold3 >= 9'd214)      r = 7'(fold3 - 9'd214);
    else if (fold3 >= 9'd107) r = 7'(fold3 - 9'd107);
  end

endmodule

module x_300_mod_107_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_r,
  output logic [3:0]  word_cnt
);

  typedef enum logic [1:0] {LOAD, CALC, HOLD} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [299:0] operand;
  logic [6:0]   residue;
  logic         accept;

  x_300_mod_107 u_mod (
    .x (operand),
    .r (residue)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Flush overrides everything, including a word accepted in the same cycle.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (word_cnt == 4'd9) state_nxt = CALC;
        end
      end
      CALC: state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
    if (flush) begin
      state_nxt = LOAD;
      accept    = 1'b0;
    end
  end

  // The operand register is not cleared between operands; all ten words overwrite it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand  <= '0;
      word_cnt <= '0;
      out_r    <= '0;
    end else if (flush) begin
      word_cnt <= '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < 9; k++) begin
          if (word_cnt == 4'(k)) operand[32*k +: 32] <= in_data;
        end
        if (word_cnt == 4'd9) operand[299:288] <= in_data[11:0];
        word_cnt <= (word_cnt == 4'd9) ? 4'd0 : word_cnt + 4'd1;
      end
      if (state == CALC) out_r <= residue;
    end
  end

endmodule

// File: tb/tb_x_300_mod_107_loader.sv
// Self-checking bench for x_300_mod_107_loader.
// A queue-based operand model supplies the expected outputs for every cycle.

module tb_x_300_mod_107_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [6:0]  out_r;
  logic [3:0]  word_cnt;

  int checks_total = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  x_300_mod_107_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .word_cnt  (word_cnt)
  );

  // X mod 107 as a sum of word residues weighted by 2^(32k) mod 107.
  function automatic int residue(input logic [31:0] w [10]);
    int acc = 0;
    int p = 1;
    int p32 = 1;
    longint v;
    for (int j = 0; j < 32; j++) p32 = (p32 * 2) % 107;
    for (int k = 0; k < 10; k++) begin
      v = (k == 9) ? longint'(w[k] & 32'h0000_0FFF) : longint'(w[k]);
      acc = (acc + int'(v % 107) * p) % 107;
      p = (p * p32) % 107;
    end
    return acc;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  logic [31:0] m_words[$];
  bit          m_calc = 0;
  bit          m_have = 0;
  int          m_r = 0;
  int          m_pending = 0;
  int          results_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_words.delete();
      m_calc = 0;
      m_have = 0;
    end else if (flush) begin
      m_words.delete();
      m_calc = 0;
      m_have = 0;
    end else if (m_have) begin
      if (out_ready) begin
        m_have = 0;
        results_done++;
      end
    end else if (m_calc) begin
      m_calc = 0;
      m_have = 1;
      m_r = m_pending;
    end else if (in_valid) begin
      m_words.push_back(in_data);
      if (m_words.size() == 10) begin
        logic [31:0] arr [10];
        for (int k = 0; k < 10; k++) arr[k] = m_words[k];
        m_pending = residue(arr);
        m_words.delete();
        m_calc = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check_output("in_ready", in_ready, (!m_calc && !m_have) ? 1 : 0);
      check_output("out_valid", out_valid, m_have ? 1 : 0);
      check_output("word_cnt", word_cnt, m_words.size());
      if (m_have) check_output("out_r", out_r, m_r);
    end
  end

  task automatic apply_stimulus(input logic [31:0] d);
    bit ok = 0;
    in_data = d;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check_output("word accept timeout", 0, 1);
  endtask

  task automatic send_operand(input logic [31:0] w [10]);
    for (int k = 0; k < 10; k++) apply_stimulus(w[k]);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      got = out_valid;
    end
  endtask

  task automatic run_case(input string name, input int idx, input logic [31:0] val, input int exp);
    logic [31:0] w [10];
    bit got;
    for (int k = 0; k < 10; k++) w[k] = '0;
    w[idx] = val;
    send_operand(w);
    wait_valid(got);
    check_output({name, " valid"}, got, 1);
    if (got) check_output(name, out_r, exp);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd107;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] w [10];
    bit got;
    logic [6:0] held;
    int base;
    int cycles;
    bit ready_seen;

    #3;
    check_output("reset in_ready", in_ready, 1);
    check_output("reset out_valid", out_valid, 0);
    check_output("reset word_cnt", word_cnt, 0);
    check_output("reset out_r", out_r, 0);

    for (int k = 0; k < 10; k++) w[k] = '0;
    w[1] = 32'd1;
    check_output("model 2^32", residue(w), 29);
    w[1] = '0; w[0] = 32'h6C;
    check_output("model 0x6C", residue(w), 1);
    w[0] = '0; w[9] = 32'hFFFF_F000;
    check_output("model mask", residue(w), 0);

    @(posedge clk);
    #1 rst_n = 1'b1;

    run_case("all zero", 0, 32'h0, 0);
    run_case("modulus", 0, 32'h6B, 0);
    run_case("modulus+1", 0, 32'h6C, 1);
    run_case("word1 weight", 1, 32'h1, 29);
    run_case("word9 mask", 9, 32'hFFFF_F000, 0);
    for (int k = 0; k < 10; k++) w[k] = '0;
    w[9] = 32'h1;
    run_case("word9 bit0", 9, 32'h1, residue(w));

    for (int k = 0; k < 10; k++) w[k] = $urandom;
    out_ready = 1'b0;
    send_operand(w);
    wait_valid(got);
    check_output("bp valid", got, 1);
    check_output("bp out_r", out_r, residue(w));
    held = out_r;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp hold valid", out_valid, 1);
      check_output("bp hold out_r", out_r, held);
      check_output("bp hold in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("bp release in_ready", in_ready, 1);
    check_output("bp release valid", out_valid, 0);
    @(posedge clk);
    #1;

    for (int k = 0; k < 4; k++) apply_stimulus(32'hFFFF_FFFF);
    in_data = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_output("flush word_cnt", word_cnt, 0);
    @(posedge clk);
    #1;
    run_case("after flush", 0, 32'h6C, 1);

    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) w[k] = 32'h1234_5678;
    send_operand(w);
    wait_valid(got);
    check_output("hold flush valid before", got, 1);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_output("hold flush valid after", out_valid, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    base = results_done;
    cycles = 0;
    in_data = rand_word();
    while (results_done - base < 1000 && cycles < 60000) begin
      @(negedge clk);
      ready_seen = in_ready;
      @(posedge clk);
      #1;
      if (in_valid && ready_seen) in_data = rand_word();
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycles++;
    end
    check_output("random operands done", (results_done - base >= 1000) ? 1 : 0, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;

    run_case("pre-reset", 1, 32'h1, 29);
    for (int k = 0; k < 10; k++) w[k] = $urandom;
    send_operand(w);
    #1 rst_n = 1'b0;
    #1;
    check_output("calc reset valid", out_valid, 0);
    check_output("calc reset in_ready", in_ready, 1);
    check_output("calc reset word_cnt", word_cnt, 0);
    check_output("calc reset out_r", out_r, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check_output("no residue after reset", out_valid, 0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
